decode_sequencer: RTL and testbench

//  Sequences commands into the decode block. Arbitrates between reader commands from the RF front end and an

---
 rtl/decode_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_decode_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_sequencer.sv
// decode_sequencer
// Feeds one command at a time into the decode block. Reader commands from the
// RF front end and an internal periodic DEFAULT_SENSOR poll are arbitrated
// round-robin. The winner is driven onto op_code_bus/user_data_bus with a
// valid/ready handshake. The sequencer then waits for decoder completion, with
// a timeout, and returns status to the reader. Poll commands complete silently.

module decode_sequencer #(
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned POLL_PERIOD = 1000,
  parameter logic [3:0]  OPC_LOOKUP  = 4'h0,
  parameter logic [3:0]  OPC_CFG_SNS = 4'h1,
  parameter logic [3:0]  OPC_DEF_SNS = 4'h2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rdr_req,
  input  logic [15:0] rdr_op_code,
  input  logic [15:0] rdr_user_data,
  output logic        rdr_ack,
  output logic [1:0]  rdr_status,
  input  logic        poll_en,
  output logic        poll_overrun,
  output logic [15:0] op_code_bus,
  output logic [15:0] user_data_bus,
  output logic        dec_valid,
  input  logic        dec_ready,
  input  logic        dec_done,
  input  logic        dec_error,
  output logic        busy
);

  // FSM encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Status codes returned to the reader
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_DEC_ERR = 2'b01;
  localparam logic [1:0] ST_BAD_OP  = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  // Requester identity used for last_grant and command ownership
  localparam logic OWNER_RDR  = 1'b0;
  localparam logic OWNER_POLL = 1'b1;

  // Terminal counter values, sized to the counters they are compared against
  localparam logic [7:0]  TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [15:0] POLL_LAST = 16'(POLL_PERIOD - 1);

  // Op code word issued by the internal poll
  localparam logic [15:0] POLL_OP   = {OPC_DEF_SNS, 12'h000};
  localparam logic [15:0] POLL_DATA = 16'h0000;

  // True when the op code nibble is one the decoder understands
  function automatic logic op_supported(input logic [3:0] nib);
    op_supported = (nib == OPC_LOOKUP) || (nib == OPC_CFG_SNS) || (nib == OPC_DEF_SNS);
  endfunction

  // Registers and next-state values
  logic [2:0]  state_q,        state_d;
  logic [15:0] poll_cnt_q,     poll_cnt_d;
  logic        poll_pending_q, poll_pending_d;
  logic        poll_requeue_q, poll_requeue_d;
  logic        poll_overrun_q, poll_overrun_d;
  logic        last_grant_q,   last_grant_d;
  logic        owner_q,        owner_d;
  logic [7:0]  wait_cnt_q,     wait_cnt_d;
  logic [15:0] op_bus_q,       op_bus_d;
  logic [15:0] data_bus_q,     data_bus_d;
  logic        dec_valid_q,    dec_valid_d;
  logic        rdr_ack_q,      rdr_ack_d;
  logic [1:0]  rdr_status_q,   rdr_status_d;
  logic        busy_q,         busy_d;

  // Combinational helpers
  logic poll_expire_s;
  logic rdr_req_s;
  logic grant_poll_s;
  logic poll_inflight_s;
  logic poll_done_s;

  // Poll timer: free-runs while enabled, cleared whenever disabled
  always_comb begin
    poll_cnt_d    = poll_cnt_q;
    poll_expire_s = 1'b0;
    if (poll_en) begin
      if (poll_cnt_q == POLL_LAST) begin
        poll_cnt_d    = 16'd0;
        poll_expire_s = 1'b1;
      end else begin
        poll_cnt_d    = poll_cnt_q + 16'd1;
      end
    end else begin
      poll_cnt_d = 16'd0;
    end
  end

  // Round-robin grant; the reader request is masked during its own ack pulse
  // so a requester that drops req on seeing ack is not granted twice
  always_comb begin
    rdr_req_s = rdr_req & ~rdr_ack_q;
    if (rdr_req_s && poll_pending_q) begin
      grant_poll_s = (last_grant_q == OWNER_RDR);
    end else if (poll_pending_q) begin
      grant_poll_s = 1'b1;
    end else begin
      grant_poll_s = 1'b0;
    end
  end

  // Poll bookkeeping: pending stays set until the poll command finishes; an
  // expiry while a poll is in flight queues exactly one follow-up poll
  always_comb begin
    poll_inflight_s = ((owner_q == OWNER_POLL) &&
                       ((state_q == S_ISSUE) || (state_q == S_WAIT))) ||
                      ((state_q == S_ARB) && grant_poll_s);
    poll_done_s     = (state_q == S_DONE) && (owner_q == OWNER_POLL);
    poll_pending_d  = poll_pending_q;
    poll_requeue_d  = poll_requeue_q;
    if (poll_done_s) begin
      poll_pending_d = poll_requeue_q | poll_expire_s;
      poll_requeue_d = 1'b0;
    end else if (poll_expire_s) begin
      poll_pending_d = 1'b1;
      if (poll_inflight_s) begin
        poll_requeue_d = 1'b1;
      end else begin
        poll_requeue_d = poll_requeue_q;
      end
    end else begin
      poll_pending_d = poll_pending_q;
    end
    poll_overrun_d = poll_overrun_q | (poll_expire_s & poll_pending_q);
  end

  // Command FSM: arbitration, issue handshake, completion wait and status
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    wait_cnt_d   = wait_cnt_q;
    op_bus_d     = op_bus_q;
    data_bus_d   = data_bus_q;
    dec_valid_d  = dec_valid_q;
    rdr_ack_d    = 1'b0;
    rdr_status_d = rdr_status_q;
    case (state_q)
      S_IDLE: begin
        if (rdr_req_s || poll_pending_q) begin
          state_d = S_ARB;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARB: begin
        if (grant_poll_s) begin
          last_grant_d = OWNER_POLL;
          owner_d      = OWNER_POLL;
          op_bus_d     = POLL_OP;
          data_bus_d   = POLL_DATA;
          dec_valid_d  = 1'b1;
          state_d      = S_ISSUE;
        end else if (rdr_req_s) begin
          last_grant_d = OWNER_RDR;
          owner_d      = OWNER_RDR;
          if (op_supported(rdr_op_code[15:12])) begin
            op_bus_d    = rdr_op_code;
            data_bus_d  = rdr_user_data;
            dec_valid_d = 1'b1;
            state_d     = S_ISSUE;
          end else begin
            // Unsupported op code: reject without touching the decoder
            rdr_ack_d    = 1'b1;
            rdr_status_d = ST_BAD_OP;
            state_d      = S_IDLE;
          end
        end else begin
          // Reader withdrew before arbitration; nothing to do
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (dec_ready) begin
          dec_valid_d = 1'b0;
          wait_cnt_d  = 8'd0;
          state_d     = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        // dec_done takes priority over the timeout on the last wait cycle
        if (dec_done) begin
          rdr_ack_d = (owner_q == OWNER_RDR);
          if (owner_q == OWNER_RDR) begin
            rdr_status_d = dec_error ? ST_DEC_ERR : ST_OK;
          end else begin
            rdr_status_d = rdr_status_q;
          end
          state_d = S_DONE;
        end else if (wait_cnt_q == TMO_LAST) begin
          rdr_ack_d = (owner_q == OWNER_RDR);
          if (owner_q == OWNER_RDR) begin
            rdr_status_d = ST_TIMEOUT;
          end else begin
            rdr_status_d = rdr_status_q;
          end
          state_d = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          state_d    = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        dec_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any command without an ack
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      poll_cnt_q     <= 16'd0;
      poll_pending_q <= 1'b0;
      poll_requeue_q <= 1'b0;
      poll_overrun_q <= 1'b0;
      last_grant_q   <= OWNER_POLL;
      owner_q        <= OWNER_RDR;
      wait_cnt_q     <= 8'd0;
      op_bus_q       <= 16'h0000;
      data_bus_q     <= 16'h0000;
      dec_valid_q    <= 1'b0;
      rdr_ack_q      <= 1'b0;
      rdr_status_q   <= 2'b00;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      poll_cnt_q     <= poll_cnt_d;
      poll_pending_q <= poll_pending_d;
      poll_requeue_q <= poll_requeue_d;
      poll_overrun_q <= poll_overrun_d;
      last_grant_q   <= last_grant_d;
      owner_q        <= owner_d;
      wait_cnt_q     <= wait_cnt_d;
      op_bus_q       <= op_bus_d;
      data_bus_q     <= data_bus_d;
      dec_valid_q    <= dec_valid_d;
      rdr_ack_q      <= rdr_ack_d;
      rdr_status_q   <= rdr_status_d;
      busy_q         <= busy_d;
    end
  end

  assign rdr_ack       = rdr_ack_q;
  assign rdr_status    = rdr_status_q;
  assign poll_overrun  = poll_overrun_q;
  assign op_code_bus   = op_bus_q;
  assign user_data_bus = data_bus_q;
  assign dec_valid     = dec_valid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_decode_sequencer.sv
// Bench for decode_sequencer. Two instances share the stimulus: A (TIMEOUT=12,
// POLL_PERIOD=8) and B (TIMEOUT=4, POLL_PERIOD=4). Expected values come from
// transaction-level rules: handshake latencies, the round-robin order and the
// poll period arithmetic.

module tb_decode_sequencer;

  localparam int TMO_A = 12;
  localparam int PER_A = 8;
  localparam int TMO_B = 4;
  localparam int PER_B = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        rdr_req, poll_en, dec_ready, dec_done, dec_error;
  logic [15:0] rdr_op_code, rdr_user_data;

  logic        a_ack, a_ovr, a_valid, a_busy;
  logic [1:0]  a_status;
  logic [15:0] a_op, a_data;
  logic        b_ack, b_ovr, b_valid, b_busy;
  logic [1:0]  b_status;
  logic [15:0] b_op, b_data;

  logic        sel;
  logic        obs_ack, obs_ovr, obs_valid, obs_busy;
  logic [1:0]  obs_status;
  logic [15:0] obs_op, obs_data;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] last_op, last_data;

  always #5 clock = ~clock;

  decode_sequencer #(.TIMEOUT(TMO_A), .POLL_PERIOD(PER_A)) u_a (
    .clock(clock), .reset(reset), .rdr_req(rdr_req), .rdr_op_code(rdr_op_code),
    .rdr_user_data(rdr_user_data), .rdr_ack(a_ack), .rdr_status(a_status),
    .poll_en(poll_en), .poll_overrun(a_ovr), .op_code_bus(a_op),
    .user_data_bus(a_data), .dec_valid(a_valid), .dec_ready(dec_ready),
    .dec_done(dec_done), .dec_error(dec_error), .busy(a_busy)
  );

  decode_sequencer #(.TIMEOUT(TMO_B), .POLL_PERIOD(PER_B)) u_b (
    .clock(clock), .reset(reset), .rdr_req(rdr_req), .rdr_op_code(rdr_op_code),
    .rdr_user_data(rdr_user_data), .rdr_ack(b_ack), .rdr_status(b_status),
    .poll_en(poll_en), .poll_overrun(b_ovr), .op_code_bus(b_op),
    .user_data_bus(b_data), .dec_valid(b_valid), .dec_ready(dec_ready),
    .dec_done(dec_done), .dec_error(dec_error), .busy(b_busy)
  );

  // Select which instance is being observed
  always_comb begin
    if (sel) begin
      obs_ack = b_ack; obs_ovr = b_ovr; obs_valid = b_valid; obs_busy = b_busy;
      obs_status = b_status; obs_op = b_op; obs_data = b_data;
    end else begin
      obs_ack = a_ack; obs_ovr = a_ovr; obs_valid = a_valid; obs_busy = a_busy;
      obs_status = a_status; obs_op = a_op; obs_data = a_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic op_ok(input logic [15:0] op);
    return (op[15:12] == 4'h0) || (op[15:12] == 4'h1) || (op[15:12] == 4'h2);
  endfunction

  task automatic do_reset(input logic s);
    sel = s;
    rdr_req = 1'b0; poll_en = 1'b0; dec_ready = 1'b0; dec_done = 1'b0; dec_error = 1'b0;
    rdr_op_code = 16'h0000; rdr_user_data = 16'h0000;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    last_op = 16'h0000; last_data = 16'h0000;
  endtask

  // One reader command with no poll traffic; r = ready delay, d = WAIT cycle of dec_done
  task automatic run_reader(input logic [15:0] op, input logic [15:0] data,
                            input int r, input int d, input logic err);
    int tmo, ack_t;
    logic ok, ev, eb;
    logic [1:0] st;
    tmo = sel ? TMO_B : TMO_A;
    ok  = op_ok(op);
    if (!ok) begin
      ack_t = 2; st = 2'b10;
    end else if (d <= tmo - 1) begin
      ack_t = 4 + r + d; st = {1'b0, err};
    end else begin
      ack_t = 3 + r + tmo; st = 2'b11;
    end
    rdr_req = 1'b1; rdr_op_code = op; rdr_user_data = data;
    dec_ready = 1'b0; dec_done = 1'b0;
    for (int t = 1; t <= ack_t + 1; t++) begin
      @(negedge clock);
      ev = ok && (t >= 2) && (t <= 2 + r);
      chk("dec_valid", obs_valid, ev);
      if (ev) begin
        chk("op_bus", obs_op, op);
        chk("data_bus", obs_data, data);
      end
      chk("rdr_ack", obs_ack, t == ack_t);
      if (t == ack_t) chk("rdr_status", obs_status, st);
      eb = (t < ack_t) || ((t == ack_t) && ok);
      chk("busy", obs_busy, eb);
      dec_ready = ok && (t == 2 + r);
      dec_done  = ok && (t == 3 + r + d);
      dec_error = dec_done ? err : 1'($urandom);
      if (t == ack_t) begin
        rdr_req = 1'b0; rdr_op_code = 16'($urandom); rdr_user_data = 16'($urandom);
      end
    end
    if (ok) begin
      last_op = op; last_data = data;
    end
    chk("op_hold", obs_op, last_op);
    chk("data_hold", obs_data, last_data);
    dec_done = 1'b0; dec_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] op, rd_op, rd_data;
    logic ev, pv, is_p, cur_poll, cur_err, exp_ack, ack_now, rearm;
    int dst, rcnt, dcnt, j, k, cyc;

    // Reset state of both instances
    do_reset(1'b0);
    reset = 1'b1;
    #1;
    chk("rst_a_valid", a_valid, 1'b0); chk("rst_a_busy", a_busy, 1'b0);
    chk("rst_a_ack", a_ack, 1'b0);     chk("rst_a_op", a_op, 16'h0000);
    chk("rst_b_ovr", b_ovr, 1'b0);     chk("rst_b_data", b_data, 16'h0000);
    @(negedge clock);
    reset = 1'b0;

    // Reader commands on A: directed ok / bad op, then random
    do_reset(1'b0);
    run_reader(16'h1234, 16'hBEEF, 0, 4, 1'b0);
    run_reader(16'h7000, 16'h1111, 0, 0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      op = 16'($urandom);
      if ($urandom_range(0, 5) < 3) op[15:12] = 4'($urandom_range(0, 2));
      else op[15:12] = 4'($urandom_range(3, 15));
      run_reader(op, 16'($urandom), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, TMO_A)), 1'($urandom));
    end

    // Reader commands on B: timeout, done on the last wait cycle, then random
    do_reset(1'b1);
    run_reader(16'h0ABC, 16'h2222, 1, 99, 1'b0);
    run_reader(16'h1ABC, 16'h3333, 0, TMO_B - 1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      op = 16'($urandom);
      op[15:12] = 4'($urandom_range(0, 3));
      run_reader(op, 16'($urandom), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, TMO_B + 1)), 1'($urandom));
    end

    // Poll only on A with an instant decoder: one issue every 8 cycles
    do_reset(1'b0);
    poll_en = 1'b1; dec_ready = 1'b1; pv = 1'b0;
    for (int t = 1; t < 50; t++) begin
      @(negedge clock);
      ev = (t >= 10) && ((t - 10) % PER_A == 0);
      chk("poll_valid", obs_valid, ev);
      if (ev) begin
        chk("poll_op", obs_op, 16'h2000);
        chk("poll_data", obs_data, 16'h0000);
      end
      chk("poll_no_ack", obs_ack, 1'b0);
      dec_done  = pv && !obs_valid;
      dec_error = 1'($urandom);
      pv = obs_valid;
    end
    chk("poll_no_overrun", obs_ovr, 1'b0);

    // Round-robin on A: reader and poll both always pending -> strict alternation
    do_reset(1'b0);
    run_reader(16'h0123, 16'h5555, 0, 1, 1'b0);
    poll_en = 1'b1;
    rd_op = 16'h1001; rd_data = 16'h00A5;
    rdr_req = 1'b1; rdr_op_code = rd_op; rdr_user_data = rd_data;
    dst = 0; rcnt = 0; dcnt = 0; j = 0; k = 0; cyc = 0;
    pv = 1'b0; exp_ack = 1'b0; rearm = 1'b0; cur_poll = 1'b0; cur_err = 1'b0;
    while ((k < 9) && (cyc < 600)) begin
      @(negedge clock);
      cyc++;
      chk("rr_ack", obs_ack, exp_ack);
      if (exp_ack) chk("rr_status", obs_status, {1'b0, cur_err});
      ack_now = exp_ack;
      exp_ack = 1'b0;
      if (obs_valid && !pv) begin
        is_p = (obs_op == 16'h2000) && (obs_data == 16'h0000);
        chk("rr_owner", is_p, (k % 2) == 1);
        if (!is_p) begin
          chk("rr_op", obs_op, rd_op);
          chk("rr_data", obs_data, rd_data);
        end
        k++;
        dst = 1; cur_poll = is_p;
        rcnt = int'($urandom_range(0, 2));
        dcnt = int'($urandom_range(8, 10));
        cur_err = 1'($urandom);
      end
      pv = obs_valid;
      dec_ready = 1'b0; dec_done = 1'b0; dec_error = 1'($urandom);
      case (dst)
        1: begin
          if (rcnt == 0) begin
            dec_ready = 1'b1; dst = 2; j = 0;
          end else begin
            rcnt--;
          end
        end
        2: begin
          if (j == dcnt) begin
            dec_done = 1'b1; dec_error = cur_err; exp_ack = !cur_poll; dst = 0;
          end
          j++;
        end
        default: ;
      endcase
      if (ack_now) begin
        rdr_req = 1'b0; rearm = 1'b1;
      end else if (rearm) begin
        rearm = 1'b0;
        rd_op = {3'b000, 1'($urandom), 12'($urandom)};
        rd_data = 16'($urandom) | 16'h0001;
        rdr_req = 1'b1; rdr_op_code = rd_op; rdr_user_data = rd_data;
      end
    end
    chk("rr_rounds", k, 9);
    chk("rr_overrun", obs_ovr, 1'b1);

    // Overrun on B with a stalled decoder, then reset mid-ISSUE
    do_reset(1'b1);
    poll_en = 1'b1; dec_ready = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      @(negedge clock);
      chk("ovr_valid", obs_valid, t >= 6);
      chk("ovr_flag", obs_ovr, t >= 8);
    end
    chk("ovr_op", obs_op, 16'h2000);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", obs_valid, 1'b0);
    chk("mid_rst_busy", obs_busy, 1'b0);
    chk("mid_rst_ovr", obs_ovr, 1'b0);
    chk("mid_rst_ack", obs_ack, 1'b0);
    chk("mid_rst_status", obs_status, 2'b00);
    chk("mid_rst_op", obs_op, 16'h0000);
    chk("mid_rst_data", obs_data, 16'h0000);
    @(negedge clock);
    reset = 1'b0; poll_en = 1'b0;
    @(negedge clock);
    chk("post_rst_busy", obs_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
